// File: rtl/stream_sram_sched_pkg.sv
// -----------------------------------------------------------------------------
// stream_sram_sched_pkg
// Shared types and constants for the stream SRAM scheduler:
//   - sched_state_e : read-burst sequencer states
//   - BURST_LEN_DEF : default number of reads per burst
//   - STALL_CNT_W   : width of the optional write-stall counter
//   - sat_inc       : saturating increment used by the stall counter
// -----------------------------------------------------------------------------
package stream_sram_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_BURST = 2'd2,
        ST_GAP   = 2'd3
    } sched_state_e;

    localparam int BURST_LEN_DEF = 8;
    localparam int STALL_CNT_W   = 16;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/stream_sram_ring.sv
// -----------------------------------------------------------------------------
// stream_sram_ring
// Ring-buffer bookkeeping for the SRAM: write/read pointers and the registered
// occupancy flags. Pointers wrap modulo 2^ADDR_WIDTH; one slot is kept unused
// so that FULL and EMPTY are distinguishable.
// Ports:
//   CLK, RESET      clock, synchronous active-high reset
//   wr_inc, rd_inc  grant strobes (never both high)
//   wr_ptr, rd_ptr  current pointers (address of the access granted this cycle)
//   fill            stored words, wr_ptr - rd_ptr modulo
//   full, empty     fill == all ones / fill == 0
// -----------------------------------------------------------------------------
module stream_sram_ring
    import stream_sram_sched_pkg::*;
#(
    parameter int ADDR_WIDTH = 19
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  wr_inc,
    input  logic                  rd_inc,
    output logic [ADDR_WIDTH-1:0] wr_ptr,
    output logic [ADDR_WIDTH-1:0] rd_ptr,
    output logic [ADDR_WIDTH-1:0] fill,
    output logic                  full,
    output logic                  empty
);

    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [ADDR_WIDTH-1:0] fill_r;
    logic                  full_r;
    logic                  empty_r;
    logic [ADDR_WIDTH-1:0] wr_ptr_nxt_s;
    logic [ADDR_WIDTH-1:0] rd_ptr_nxt_s;
    logic [ADDR_WIDTH-1:0] fill_nxt_s;

    // Next pointer values and the occupancy they imply.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r + {{(ADDR_WIDTH-1){1'b0}}, wr_inc};
        rd_ptr_nxt_s = rd_ptr_r + {{(ADDR_WIDTH-1){1'b0}}, rd_inc};
        fill_nxt_s   = wr_ptr_nxt_s - rd_ptr_nxt_s;
    end

    // Pointer and flag registers; flags are derived from next values so they
    // track the pointers with no extra lag.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_r <= {ADDR_WIDTH{1'b0}};
            rd_ptr_r <= {ADDR_WIDTH{1'b0}};
            fill_r   <= {ADDR_WIDTH{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            fill_r   <= fill_nxt_s;
            full_r   <= &fill_nxt_s;
            empty_r  <= (fill_nxt_s == {ADDR_WIDTH{1'b0}});
        end
    end

    assign wr_ptr = wr_ptr_r;
    assign rd_ptr = rd_ptr_r;
    assign fill   = fill_r;
    assign full   = full_r;
    assign empty  = empty_r;

endmodule

// File: rtl/stream_sram_sched.sv
// -----------------------------------------------------------------------------
// stream_sram_sched
// Time-shares one single-port SRAM between the CDC-FIFO write side and the
// USB stream read side. Reads come in bursts of up to BURST_LEN words, armed
// by two consecutive STREAM_READY cycles and separated by one GAP cycle; the
// GAP/ARM cycles never read, which bounds write starvation.
// Ports:
//   CLK, RESET                  clock, synchronous active-high reset
//   WR_VALID, WR_DATA, WR_ACK   write source; WR_ACK is a combinational pop
//   RD_COUNT_LOAD, RD_COUNT     load a new read request (overrides any burst)
//   STREAM_READY                sink can take a burst
//   SRAM_WE/RD/ADDR/WDATA       registered access, one cycle after the grant
//   FILL, REMAIN, FULL, EMPTY   registered ring/request status
//   BUSY                        sequencer not in IDLE
// Optional build macro STREAM_SRAM_SCHED_STATS_EN adds STALL_CNT, a saturating
// count of cycles with WR_VALID & !WR_ACK.
// -----------------------------------------------------------------------------
module stream_sram_sched
    import stream_sram_sched_pkg::*;
#(
    parameter int ADDR_WIDTH  = 19,
    parameter int DATA_WIDTH  = 16,
    parameter int COUNT_WIDTH = 24,
    parameter int BURST_LEN   = BURST_LEN_DEF
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   WR_VALID,
    input  logic [DATA_WIDTH-1:0]  WR_DATA,
    output logic                   WR_ACK,
    input  logic                   RD_COUNT_LOAD,
    input  logic [COUNT_WIDTH-1:0] RD_COUNT,
    input  logic                   STREAM_READY,
    output logic                   SRAM_WE,
    output logic                   SRAM_RD,
    output logic [ADDR_WIDTH-1:0]  SRAM_ADDR,
    output logic [DATA_WIDTH-1:0]  SRAM_WDATA,
    output logic [ADDR_WIDTH-1:0]  FILL,
    output logic [COUNT_WIDTH-1:0] REMAIN,
    output logic                   FULL,
    output logic                   EMPTY,
`ifdef STREAM_SRAM_SCHED_STATS_EN
    output logic [STALL_CNT_W-1:0] STALL_CNT,
`endif
    output logic                   BUSY
);

    localparam int BCW = $clog2(BURST_LEN) + 1;

    sched_state_e           state_r;
    sched_state_e           state_nxt_s;
    logic                   arm_ok_r;
    logic [COUNT_WIDTH-1:0] remain_r;
    logic [BCW-1:0]         burst_cnt_r;
    logic [BCW-1:0]         burst_cnt_inc_s;
    logic                   burst_last_s;
    logic                   remain_zero_s;
    logic                   remain_one_s;
    logic                   rd_grant_s;
    logic                   wr_grant_s;
    logic                   busy_s;
    logic                   sram_we_r;
    logic                   sram_rd_r;
    logic [ADDR_WIDTH-1:0]  sram_addr_r;
    logic [DATA_WIDTH-1:0]  sram_wdata_r;
    logic [ADDR_WIDTH-1:0]  wr_ptr_s;
    logic [ADDR_WIDTH-1:0]  rd_ptr_s;
    logic [ADDR_WIDTH-1:0]  fill_s;
    logic                   full_s;
    logic                   empty_s;

    stream_sram_ring #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ring (
        .CLK    (CLK),
        .RESET  (RESET),
        .wr_inc (wr_grant_s),
        .rd_inc (rd_grant_s),
        .wr_ptr (wr_ptr_s),
        .rd_ptr (rd_ptr_s),
        .fill   (fill_s),
        .full   (full_s),
        .empty  (empty_s)
    );

    assign burst_cnt_inc_s = burst_cnt_r + {{(BCW-1){1'b0}}, 1'b1};
    assign burst_last_s    = (burst_cnt_inc_s == BCW'(BURST_LEN));
    assign remain_zero_s   = (remain_r == {COUNT_WIDTH{1'b0}});
    assign remain_one_s    = (remain_r == {{(COUNT_WIDTH-1){1'b0}}, 1'b1});

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a request load always restarts from IDLE.
    always_comb begin
        state_nxt_s = state_r;
        if (RD_COUNT_LOAD) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:  state_nxt_s = remain_zero_s ? ST_IDLE : ST_ARM;
                ST_ARM:   state_nxt_s = (STREAM_READY && arm_ok_r) ? ST_BURST : ST_ARM;
                ST_BURST: begin
                    if (rd_grant_s && (burst_last_s || remain_one_s)) begin
                        state_nxt_s = ST_GAP;
                    end else if (remain_zero_s) begin
                        state_nxt_s = ST_GAP;
                    end else begin
                        state_nxt_s = ST_BURST;
                    end
                end
                ST_GAP:   state_nxt_s = remain_zero_s ? ST_IDLE : ST_ARM;
                default:  state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Grant arbitration: reads win; the load cycle never reads.
    always_comb begin
        rd_grant_s = 1'b0;
        wr_grant_s = 1'b0;
        busy_s     = (state_r != ST_IDLE);
        if ((state_r == ST_BURST) && !empty_s && !remain_zero_s && !RD_COUNT_LOAD) begin
            rd_grant_s = 1'b1;
        end else begin
            rd_grant_s = 1'b0;
        end
        wr_grant_s = WR_VALID && !full_s && !rd_grant_s;
    end

    // Request counter, burst counter and the READY-history flag used by ARM.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            remain_r    <= {COUNT_WIDTH{1'b0}};
            burst_cnt_r <= {BCW{1'b0}};
            arm_ok_r    <= 1'b0;
        end else begin
            if (RD_COUNT_LOAD) begin
                remain_r <= RD_COUNT;
            end else if (rd_grant_s) begin
                remain_r <= remain_r - {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                remain_r <= remain_r;
            end
            // Counter only runs inside BURST, so entering BURST starts at zero.
            if (state_r != ST_BURST) begin
                burst_cnt_r <= {BCW{1'b0}};
            end else if (rd_grant_s) begin
                burst_cnt_r <= burst_cnt_inc_s;
            end else begin
                burst_cnt_r <= burst_cnt_r;
            end
            arm_ok_r <= (state_r == ST_ARM) && STREAM_READY;
        end
    end

    // SRAM access register stage: strobe, address and data one cycle after grant.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sram_we_r    <= 1'b0;
            sram_rd_r    <= 1'b0;
            sram_addr_r  <= {ADDR_WIDTH{1'b0}};
            sram_wdata_r <= {DATA_WIDTH{1'b0}};
        end else begin
            sram_we_r <= wr_grant_s;
            sram_rd_r <= rd_grant_s;
            if (rd_grant_s) begin
                sram_addr_r <= rd_ptr_s;
            end else if (wr_grant_s) begin
                sram_addr_r  <= wr_ptr_s;
                sram_wdata_r <= WR_DATA;
            end else begin
                sram_addr_r <= sram_addr_r;
            end
        end
    end

`ifdef STREAM_SRAM_SCHED_STATS_EN
    logic [STALL_CNT_W-1:0] stall_cnt_r;

    // Saturating count of cycles where the source offered a word but was refused.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_cnt_r <= {STALL_CNT_W{1'b0}};
        end else if (WR_VALID && !wr_grant_s) begin
            stall_cnt_r <= sat_inc(stall_cnt_r);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign STALL_CNT = stall_cnt_r;
`endif

    assign WR_ACK     = wr_grant_s;
    assign SRAM_WE    = sram_we_r;
    assign SRAM_RD    = sram_rd_r;
    assign SRAM_ADDR  = sram_addr_r;
    assign SRAM_WDATA = sram_wdata_r;
    assign FILL       = fill_s;
    assign REMAIN     = remain_r;
    assign FULL       = full_s;
    assign EMPTY      = empty_s;
    assign BUSY       = busy_s;

endmodule

// File: tb/tb_stream_sram_sched.sv
// -----------------------------------------------------------------------------
// tb_stream_sram_sched
// Directed bench for stream_sram_sched with ADDR_WIDTH = 4 (15-word ring).
// Stimulus pushes expected SRAM accesses into write/read queues; a monitor on
// the falling edge pops and compares every SRAM_WE / SRAM_RD strobe and logs
// the cycle it occurred in for burst-timing checks.
// -----------------------------------------------------------------------------
module tb_stream_sram_sched;

    typedef struct packed {
        logic [3:0]  addr;
        logic [15:0] data;
    } wr_exp_t;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        WR_VALID;
    logic [15:0] WR_DATA;
    logic        WR_ACK;
    logic        RD_COUNT_LOAD;
    logic [23:0] RD_COUNT;
    logic        STREAM_READY;
    logic        SRAM_WE;
    logic        SRAM_RD;
    logic [3:0]  SRAM_ADDR;
    logic [15:0] SRAM_WDATA;
    logic [3:0]  FILL;
    logic [23:0] REMAIN;
    logic        FULL;
    logic        EMPTY;
    logic        BUSY;
`ifdef STREAM_SRAM_SCHED_STATS_EN
    logic [15:0] STALL_CNT;
`endif

    stream_sram_sched #(
        .ADDR_WIDTH  (4),
        .DATA_WIDTH  (16),
        .COUNT_WIDTH (24),
        .BURST_LEN   (8)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .WR_VALID      (WR_VALID),
        .WR_DATA       (WR_DATA),
        .WR_ACK        (WR_ACK),
        .RD_COUNT_LOAD (RD_COUNT_LOAD),
        .RD_COUNT      (RD_COUNT),
        .STREAM_READY  (STREAM_READY),
        .SRAM_WE       (SRAM_WE),
        .SRAM_RD       (SRAM_RD),
        .SRAM_ADDR     (SRAM_ADDR),
        .SRAM_WDATA    (SRAM_WDATA),
        .FILL          (FILL),
        .REMAIN        (REMAIN),
        .FULL          (FULL),
        .EMPTY         (EMPTY),
`ifdef STREAM_SRAM_SCHED_STATS_EN
        .STALL_CNT     (STALL_CNT),
`endif
        .BUSY          (BUSY)
    );

    always #5 CLK = ~CLK;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    wr_exp_t    wq[$];
    logic [3:0] rq[$];
    int         we_cyc[$];
    int         rd_cyc[$];

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endfunction

    // Scoreboard monitor: every strobe must match the oldest expected access.
    always @(negedge CLK) begin
        if (!RESET) begin
            if (SRAM_WE && SRAM_RD) begin
                chk("we_rd_exclusive", 32'd1, 32'd0);
            end
            if (SRAM_WE) begin
                we_cyc.push_back(cyc);
                if (wq.size() == 0) begin
                    chk("unexpected_we", 32'd1, 32'd0);
                end else begin
                    wr_exp_t e;
                    e = wq.pop_front();
                    chk("we_addr", 32'(SRAM_ADDR), 32'(e.addr));
                    chk("we_data", 32'(SRAM_WDATA), 32'(e.data));
                end
            end
            if (SRAM_RD) begin
                rd_cyc.push_back(cyc);
                if (rq.size() == 0) begin
                    chk("unexpected_rd", 32'd1, 32'd0);
                end else begin
                    logic [3:0] a;
                    a = rq.pop_front();
                    chk("rd_addr", 32'(SRAM_ADDR), 32'(a));
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET         = 1'b1;
        WR_VALID      = 1'b0;
        WR_DATA       = 16'h0000;
        RD_COUNT_LOAD = 1'b0;
        RD_COUNT      = 24'd0;
        STREAM_READY  = 1'b0;
        repeat (3) step();
        @(negedge CLK);
        chk("rst_we", 32'(SRAM_WE), 32'd0);
        chk("rst_rd", 32'(SRAM_RD), 32'd0);
        chk("rst_addr", 32'(SRAM_ADDR), 32'd0);
        chk("rst_wdata", 32'(SRAM_WDATA), 32'd0);
        chk("rst_fill", 32'(FILL), 32'd0);
        chk("rst_remain", 32'(REMAIN), 32'd0);
        chk("rst_full", 32'(FULL), 32'd0);
        chk("rst_empty", 32'(EMPTY), 32'd1);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_wr_ack", 32'(WR_ACK), 32'd0);
`ifdef STREAM_SRAM_SCHED_STATS_EN
        chk("rst_stall_cnt", 32'(STALL_CNT), 32'd0);
`endif
        wq.delete();
        rq.delete();
        we_cyc.delete();
        rd_cyc.delete();
        step();
        RESET = 1'b0;
    endtask

    // Offer n words until all are accepted; expected addresses start at a0.
    task automatic write_words(input int n, input logic [15:0] base, input int a0);
        int got = 0;
        int guard = 0;
        WR_VALID = 1'b1;
        WR_DATA  = base;
        while (got < n && guard < 200) begin
            @(negedge CLK);
            if (WR_ACK) begin
                wr_exp_t e;
                e.addr = 4'((a0 + got) % 16);
                e.data = base + 16'(got);
                wq.push_back(e);
                got++;
            end
            step();
            WR_DATA = base + 16'(got);
            guard++;
        end
        WR_VALID = 1'b0;
        chk("write_words_done", 32'(got), 32'(n));
    endtask

    task automatic drain_check(input string tag);
        repeat (3) step();
        chk({tag, "_wq_empty"}, 32'(wq.size()), 32'd0);
        chk({tag, "_rq_empty"}, 32'(rq.size()), 32'd0);
    endtask

    initial begin
        int  wr_cnt;
        bit  loaded;
        bit  acc;
        bit  do_load;
        int  load_cyc;

        // ---- 10 writes, no read request ----
        do_reset();
        write_words(10, 16'hA000, 0);
        step();
        step();
        chk("t1_fill", 32'(FILL), 32'd10);
        chk("t1_busy", 32'(BUSY), 32'd0);
        chk("t1_empty", 32'(EMPTY), 32'd0);
        chk("t1_we_count", 32'(we_cyc.size()), 32'd10);
        drain_check("t1");

        // ---- fill to 15, read 20 in bursts 8/8/4 with WR_VALID held ----
        do_reset();
        WR_VALID     = 1'b1;
        WR_DATA      = 16'hB000;
        STREAM_READY = 1'b1;
        wr_cnt   = 0;
        loaded   = 1'b0;
        load_cyc = 0;
        for (int c = 0; c < 300; c++) begin
            if (loaded && cyc >= load_cyc + 34) break;
            @(negedge CLK);
            acc = WR_VALID && WR_ACK;
            if (acc) begin
                wr_exp_t e;
                e.addr = 4'(wr_cnt % 16);
                e.data = 16'hB000 + 16'(wr_cnt);
                wq.push_back(e);
            end
            do_load = !loaded && FULL;
            if (do_load) begin
                chk("t2_full_fill", 32'(FILL), 32'd15);
                chk("t2_full_at_15", 32'(wr_cnt), 32'd15);
                chk("t2_full_no_ack", 32'(WR_ACK), 32'd0);
            end
            if (loaded && cyc == load_cyc + 5) begin
                chk("t2_read_clears_full", 32'(FULL), 32'd0);
            end
            step();
            RD_COUNT_LOAD = 1'b0;
            if (acc) begin
                wr_cnt++;
                WR_DATA = 16'hB000 + 16'(wr_cnt);
                if (wr_cnt == 21) WR_VALID = 1'b0;
            end
            if (do_load) begin
                RD_COUNT_LOAD = 1'b1;
                RD_COUNT      = 24'd20;
                loaded        = 1'b1;
                load_cyc      = cyc;
                for (int i = 0; i < 20; i++) rq.push_back(4'(i % 16));
            end
        end
        RD_COUNT_LOAD = 1'b0;
        WR_VALID      = 1'b0;
        chk("t2_loaded", 32'(loaded), 32'd1);
        chk("t2_rd_count", 32'(rd_cyc.size()), 32'd20);
        chk("t2_wr_count", 32'(wr_cnt), 32'd21);
        if (rd_cyc.size() >= 20) begin
            chk("t2_first_rd_t5", 32'(rd_cyc[0]), 32'(load_cyc + 5));
            chk("t2_burst1_end", 32'(rd_cyc[7]), 32'(load_cyc + 12));
            chk("t2_burst2_start", 32'(rd_cyc[8]), 32'(load_cyc + 16));
            chk("t2_burst2_end", 32'(rd_cyc[15]), 32'(load_cyc + 23));
            chk("t2_burst3_start", 32'(rd_cyc[16]), 32'(load_cyc + 27));
            chk("t2_burst3_end", 32'(rd_cyc[19]), 32'(load_cyc + 30));
        end
        if (we_cyc.size() >= 19) begin
            chk("t2_write_in_gap1", 32'(we_cyc[15]), 32'(load_cyc + 13));
            chk("t2_write_in_gap2", 32'(we_cyc[18]), 32'(load_cyc + 24));
        end
        chk("t2_remain", 32'(REMAIN), 32'd0);
        chk("t2_busy", 32'(BUSY), 32'd0);
        chk("t2_fill", 32'(FILL), 32'd1);
`ifdef STREAM_SRAM_SCHED_STATS_EN
        chk("t2_stall_cnt", 32'(STALL_CNT), 32'd21);
`endif
        drain_check("t2");

        // ---- request 12 with only 5 stored: stall on EMPTY, then complete ----
        do_reset();
        write_words(5, 16'hC000, 0);
        RD_COUNT      = 24'd12;
        RD_COUNT_LOAD = 1'b1;
        STREAM_READY  = 1'b1;
        for (int i = 0; i < 12; i++) rq.push_back(4'(i));
        step();
        RD_COUNT_LOAD = 1'b0;
        for (int g = 0; g < 40 && rd_cyc.size() < 5; g++) step();
        repeat (6) step();
        chk("t3_stall_reads", 32'(rd_cyc.size()), 32'd5);
        chk("t3_stall_busy", 32'(BUSY), 32'd1);
        chk("t3_stall_remain", 32'(REMAIN), 32'd7);
        chk("t3_stall_empty", 32'(EMPTY), 32'd1);
        write_words(7, 16'hC005, 5);
        for (int g = 0; g < 80 && (BUSY || REMAIN != 24'd0); g++) step();
        chk("t3_remain", 32'(REMAIN), 32'd0);
        chk("t3_busy", 32'(BUSY), 32'd0);
        drain_check("t3");
        chk("t3_rd_count", 32'(rd_cyc.size()), 32'd12);

        // ---- reload with 3 after 4 burst reads ----
        do_reset();
        write_words(8, 16'hD000, 0);
        RD_COUNT      = 24'd8;
        RD_COUNT_LOAD = 1'b1;
        STREAM_READY  = 1'b1;
        for (int i = 0; i < 7; i++) rq.push_back(4'(i));
        step();
        RD_COUNT_LOAD = 1'b0;
        for (int g = 0; g < 60 && rd_cyc.size() < 3; g++) begin
            @(negedge CLK);
            #1;
        end
        @(posedge CLK);
        #1;
        RD_COUNT_LOAD = 1'b1;
        RD_COUNT      = 24'd3;
        load_cyc      = cyc;
        step();
        RD_COUNT_LOAD = 1'b0;
        for (int g = 0; g < 60 && (BUSY || REMAIN != 24'd0); g++) step();
        drain_check("t4");
        chk("t4_rd_count", 32'(rd_cyc.size()), 32'd7);
        if (rd_cyc.size() >= 7) begin
            chk("t4_last_pre_load", 32'(rd_cyc[3]), 32'(load_cyc));
            chk("t4_rearm_first", 32'(rd_cyc[4]), 32'(load_cyc + 5));
            chk("t4_rearm_last", 32'(rd_cyc[6]), 32'(load_cyc + 7));
        end
        chk("t4_remain", 32'(REMAIN), 32'd0);
        chk("t4_busy", 32'(BUSY), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
